melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a fixed melody by stepping through a note table on a tempo tick. For each step it drives a note select and a gate. These feed the per-note tone generators: the gate drives their `switch` input, and the note select chooses which generator's `speaker` output reaches the pin. Sits directly upstream of the tone generators and replaces manual switch control with timed playback.

## Interface
- `CLK_MHZ`, 20: system clock in MHz; documentation and derivation of `TICK_CYCLES` only.
- `TICK_CYCLES`, 1250000: clock cycles per duration tick (62.5 ms at 20 MHz).
- `TICK_W`, 21: tick counter width; must satisfy 2^`TICK_W` > `TICK_CYCLES`.
- `SONG_LEN`, 32: note table depth; step index width is 5 bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins playback at step 0.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `loop`  in  1  level; sampled when the end of the song is reached.
- `note_sel`  out  4  note code of the current step (0 = rest, 1..12 = C3..B3).
- `gate`  out  1  high while a non-rest note sounds; drives the tone generators' `switch`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural completion.
- `step`  out  5  current table index.

## Operation
- Table entry: 4-bit note code plus 4-bit duration in ticks.
  - Duration 0 means 16 ticks.
  - Note code 15 is END.
  - Codes 13 and 14 play as rest.
- States: IDLE, LOAD, SOUND, GAP.
  - IDLE: all outputs 0. `start` → LOAD with `step`=0.
  - LOAD (1 cycle): read entry[`step`]; load the duration counter; clear the tick counter.
    - Non-END entry → SOUND.
    - END with `loop`=1 and `step`≠0 → `step`=0, stay in LOAD.
    - END otherwise (including END at step 0) → IDLE and pulse `done`.
  - SOUND: `note_sel` = code; `gate` = (code ≠ 0). Lasts duration×`TICK_CYCLES` cycles, then → GAP.
  - GAP: `gate`=0 and `note_sel` is held. Lasts `TICK_CYCLES` cycles, giving articulation between notes.
    - At GAP end: if `step`=`SONG_LEN`−1, treat as END (loop → `step`=0 and LOAD; else IDLE and `done`).
    - Otherwise `step`+1 → LOAD.
- Tick counter: counts 0..`TICK_CYCLES`−1 and wraps. The tick event fires at `TICK_CYCLES`−1. Counter is cleared in LOAD.
- `stop` in any state → IDLE at the next edge. No `done` pulse.
- `start` while busy → restart: LOAD with `step`=0.
- `start` and `stop` in the same cycle: `stop` wins.
- `loop` is only sampled at the end of the song. Dropping it mid-song finishes the current pass.
- Default table: step0 {G3=8, dur 4}; step1 {rest, 2}; step2 {E3=5, 2}; step3 END; all remaining entries END.

## Timing
- All outputs are registered.
- Reset values: `note_sel`=0, `gate`=0, `busy`=0, `done`=0, `step`=0; state IDLE; counters 0. Reset applies immediately and asynchronously, including mid-note.
- `start` sampled at edge N: LOAD during N..N+1. SOUND from edge N+1, with `gate` and `note_sel` valid in the cycle after that edge.
- Cycles per non-END step: 1 (LOAD) + dur×`TICK_CYCLES` + `TICK_CYCLES`.
- `done` is high for exactly one cycle: the first IDLE cycle after the terminating LOAD or GAP.
- `stop` at edge N: `gate`=0 and `busy`=0 from edge N+1.

## Structure
- Shared package `tone_pkg`:
  - note code constants (`NOTE_REST`, `NOTE_C3`..`NOTE_B3`, `NOTE_END`);
  - entry field widths;
  - the per-note tone-generator reset values, shared with the tone generators.
- Sub-module `melody_rom`: combinational case lookup from `step` to {note, dur}. Holds the default table and can be swapped per song.
- Sequencer FSM, tick counter and duration counter live in `melody_sequencer`.

## Test plan
All scenarios run with `TICK_CYCLES`=4.
- Default song, `loop`=0, `start` at edge N:
  - `gate`=1, `note_sel`=8 for 16 cycles.
  - Then `gate`=0 for 4 + 1 + 8 + 4 + 1 cycles.
  - Then `gate`=1, `note_sel`=5 for 8 cycles.
  - Then `done` pulses once, 6 cycles after that note ends, and `busy` falls with it.
- `loop`=1: after the E3 GAP, LOAD reads END, and `gate` rises again with `note_sel`=8 two cycles later. No `done`.
- `stop` 5 cycles into G3: `gate`=0 and `busy`=0 next cycle. `done` stays 0.
- `start` re-pulsed during the E3 note: `step` returns to 0 and G3 is replayed for the full 16 cycles.
- `rst` asserted mid-SOUND (asynchronously, between edges): all outputs are 0 immediately. After release, nothing plays until `start`.
- Table patched so step0 = END, `loop`=1: `done` pulses once after LOAD, then IDLE. No lock-up.

Source files
------------

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note codes, table entry layout and tone generator reset values
package tone_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C3   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS3  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D3   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS3  = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E3   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F3   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS3  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G3   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS3  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A3   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS3  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B3   = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'd15;

  // Idle levels the tone generators come out of reset with.
  localparam logic TONE_SWITCH_RST  = 1'b0;
  localparam logic TONE_SPEAKER_RST = 1'b0;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SOUND, ST_GAP} seq_state_t;

  // Codes 13 and 14 are unused slots and sound as silence.
  function automatic logic [NOTE_W-1:0] play_note(input logic [NOTE_W-1:0] code);
    return (code > NOTE_B3) ? NOTE_REST : code;
  endfunction

  function automatic logic [DUR_W:0] dur_ticks(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? 5'd16 : {1'b0, dur};
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - note table lookup; SONG_ID 1 is an empty song (END at step 0)
module melody_rom
  import tone_pkg::*;
#(
  parameter int SONG_ID = 0
) (
  input  logic [4:0]        step_i,
  output logic [NOTE_W-1:0] note_o,
  output logic [DUR_W-1:0]  dur_o
);

  always_comb begin
    note_o = NOTE_END;
    dur_o  = '0;
    if (SONG_ID == 0) begin
      case (step_i)
        5'd0: begin note_o = NOTE_G3;   dur_o = 4'd4; end
        5'd1: begin note_o = NOTE_REST; dur_o = 4'd2; end
        5'd2: begin note_o = NOTE_E3;   dur_o = 4'd2; end
        default: begin note_o = NOTE_END; dur_o = '0; end
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps the note table on a tempo tick, driving note select and gate
module melody_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_MHZ     = 20,
  parameter int TICK_CYCLES = CLK_MHZ * 62500,
  parameter int TICK_W      = 21,
  parameter int SONG_LEN    = 32,
  parameter int SONG_ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [NOTE_W-1:0] note_sel,
  output logic              gate,
  output logic              busy,
  output logic              done,
  output logic [4:0]        step
);

  seq_state_t        state_q;
  logic [4:0]        step_q;
  logic [TICK_W-1:0] tick_q;
  logic [DUR_W:0]    dur_q;
  logic [NOTE_W-1:0] note_q;
  logic              gate_q;
  logic              busy_q;
  logic              done_q;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              tick_evt;
  logic              last_step;

  melody_rom #(.SONG_ID(SONG_ID)) u_rom (
    .step_i(step_q),
    .note_o(rom_note),
    .dur_o (rom_dur)
  );

  assign tick_evt  = (tick_q == TICK_W'(TICK_CYCLES - 1));
  assign last_step = (step_q == 5'(SONG_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      note_q  <= NOTE_REST;
      gate_q  <= TONE_SWITCH_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        step_q  <= '0;
        tick_q  <= '0;
        dur_q   <= '0;
        note_q  <= NOTE_REST;
        gate_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q <= ST_LOAD;
        step_q  <= '0;
        tick_q  <= '0;
        gate_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_LOAD: begin
            tick_q <= '0;
            dur_q  <= dur_ticks(rom_dur);
            if (rom_note != NOTE_END) begin
              state_q <= ST_SOUND;
              note_q  <= play_note(rom_note);
              gate_q  <= (play_note(rom_note) != NOTE_REST);
            end else if (loop && step_q != '0) begin
              step_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              step_q  <= '0;
              note_q  <= NOTE_REST;
              gate_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_SOUND: begin
            if (tick_evt) begin
              tick_q <= '0;
              if (dur_q == 5'd1) begin
                state_q <= ST_GAP;
                gate_q  <= 1'b0;
              end else begin
                dur_q <= dur_q - 5'd1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          ST_GAP: begin
            if (tick_evt) begin
              tick_q <= '0;
              // The final table slot ends the song even without an END entry.
              if (!last_step) begin
                step_q  <= step_q + 5'd1;
                state_q <= ST_LOAD;
              end else if (loop) begin
                step_q  <= '0;
                state_q <= ST_LOAD;
              end else begin
                state_q <= ST_IDLE;
                step_q  <= '0;
                note_q  <= NOTE_REST;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign note_sel = note_q;
  assign gate     = gate_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step     = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer with TICK_CYCLES=4
module tb_melody_sequencer;

  localparam int T   = 4;
  localparam int LEN = 32;

  logic clk, rst, start, stop, loop, start_e;
  logic [3:0] note_sel, e_note_sel;
  logic gate, busy, done, e_gate, e_busy, e_done;
  logic [4:0] step, e_step;

  int n_pass = 0;
  int n_total = 0;

  melody_sequencer #(.TICK_CYCLES(T), .TICK_W(3), .SONG_LEN(LEN), .SONG_ID(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .note_sel(note_sel), .gate(gate), .busy(busy), .done(done), .step(step)
  );

  melody_sequencer #(.TICK_CYCLES(T), .TICK_W(3), .SONG_LEN(LEN), .SONG_ID(1)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .stop(1'b0), .loop(loop),
    .note_sel(e_note_sel), .gate(e_gate), .busy(e_busy), .done(e_done), .step(e_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] note;
    logic       gate;
    logic       busy;
    logic       done;
    logic [4:0] step;
  } rec_t;

  int   tbl_note [LEN];
  int   tbl_dur  [LEN];
  rec_t q[$];
  rec_t cur = '0;
  bit   active = 0;
  bit   end_zero = 0;

  initial begin
    for (int i = 0; i < LEN; i++) begin tbl_note[i] = 15; tbl_dur[i] = 0; end
    tbl_note[0] = 8; tbl_dur[0] = 4;
    tbl_note[1] = 0; tbl_dur[1] = 2;
    tbl_note[2] = 5; tbl_dur[2] = 2;
  end

  // Expected output for every cycle of one pass, starting with its first LOAD cycle.
  task automatic build_pass(input logic [3:0] held_in);
    logic [3:0] held, sn;
    int d;
    held = held_in;
    for (int s = 0; s < LEN; s++) begin
      q.push_back('{held, 1'b0, 1'b1, 1'b0, 5'(s)});
      if (tbl_note[s] == 15) begin
        end_zero = (s == 0);
        return;
      end
      d  = (tbl_dur[s] == 0) ? 16 : tbl_dur[s];
      sn = (tbl_note[s] > 12) ? 4'd0 : 4'(tbl_note[s]);
      for (int c = 0; c < d * T; c++) q.push_back('{sn, sn != 0, 1'b1, 1'b0, 5'(s)});
      for (int c = 0; c < T; c++)     q.push_back('{sn, 1'b0, 1'b1, 1'b0, 5'(s)});
      held = sn;
    end
    end_zero = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur = '0;
      active = 0;
    end else if (stop) begin
      q.delete();
      cur = '0;
      active = 0;
    end else if (start) begin
      q.delete();
      build_pass(cur.note);
      cur = q.pop_front();
      active = 1;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (active) begin
      if (loop && !end_zero) begin
        build_pass(cur.note);
        cur = q.pop_front();
      end else begin
        cur = '{4'd0, 1'b0, 1'b0, 1'b1, 5'd0};
        active = 0;
      end
    end else begin
      cur = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      rec_t act;
      act = '{note_sel, gate, busy, done, step};
      n_total++;
      if (act === cur) n_pass++;
      else $display("FAIL model t=%0t act note=%0d gate=%0b busy=%0b done=%0b step=%0d exp note=%0d gate=%0b busy=%0b done=%0b step=%0d",
                    $time, act.note, act.gate, act.busy, act.done, act.step,
                    cur.note, cur.gate, cur.busy, cur.done, cur.step);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; loop = 0; start_e = 0;
    adv(2);
    chk("rst_note", note_sel, 0); chk("rst_gate", gate, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);     chk("rst_step", step, 0);
    rst = 1'b0;
    adv(3);

    // Default song, no loop
    pulse_start();
    chk("s1_load_busy", busy, 1); chk("s1_load_gate", gate, 0);
    adv(1);  chk("s1_g3_gate_first", gate, 1); chk("s1_g3_note", note_sel, 8);
    adv(15); chk("s1_g3_gate_last", gate, 1);
    adv(1);  chk("s1_gap_gate", gate, 0); chk("s1_gap_note_held", note_sel, 8);
    adv(17); chk("s1_pre_e3_gate", gate, 0);
    adv(1);  chk("s1_e3_gate_first", gate, 1); chk("s1_e3_note", note_sel, 5);
    adv(7);  chk("s1_e3_gate_last", gate, 1);
    adv(1);  chk("s1_e3_gap", gate, 0);
    adv(4);  chk("s1_end_load_busy", busy, 1); chk("s1_end_load_done", done, 0);
    adv(1);  chk("s1_done", done, 1); chk("s1_done_busy", busy, 0);
    adv(1);  chk("s1_done_pulse", done, 0);
    adv(5);

    // Looping: G3 returns two cycles after END is read
    loop = 1'b1;
    pulse_start();
    adv(48); chk("s2_relaod_busy", busy, 1); chk("s2_reload_done", done, 0); chk("s2_reload_step", step, 0);
    adv(1);  chk("s2_regate", gate, 1); chk("s2_renote", note_sel, 8);
    loop = 1'b0;
    adv(55); chk("s2_finished", busy, 0);

    // Stop mid-note
    pulse_start();
    adv(5); stop = 1'b1;
    adv(1); stop = 1'b0;
    chk("s3_stop_gate", gate, 0); chk("s3_stop_busy", busy, 0); chk("s3_stop_done", done, 0);
    adv(5); chk("s3_no_done", done, 0);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    adv(1); start = 1'b0; stop = 1'b0;
    chk("s3b_busy", busy, 0);
    adv(3);

    // Restart during E3
    pulse_start();
    adv(37); pulse_start();
    chk("s4_restart_step", step, 0); chk("s4_restart_busy", busy, 1); chk("s4_restart_gate", gate, 0);
    adv(1);  chk("s4_g3_gate", gate, 1); chk("s4_g3_note", note_sel, 8);
    adv(15); chk("s4_g3_full", gate, 1);
    adv(1);  chk("s4_g3_end", gate, 0);
    adv(40);

    // Asynchronous reset mid-SOUND
    pulse_start();
    adv(8); #2 rst = 1'b1;
    #1;
    chk("s5_rst_gate", gate, 0); chk("s5_rst_busy", busy, 0); chk("s5_rst_note", note_sel, 0);
    chk("s5_rst_step", step, 0);
    @(negedge clk); #3 rst = 1'b0;
    adv(20); chk("s5_quiet_busy", busy, 0); chk("s5_quiet_gate", gate, 0);

    // Empty song with loop set must still terminate
    loop = 1'b1;
    start_e = 1'b1; @(negedge clk); start_e = 1'b0;
    chk("s6_load_busy", e_busy, 1); chk("s6_load_done", e_done, 0);
    adv(1); chk("s6_done", e_done, 1); chk("s6_idle", e_busy, 0);
    adv(1); chk("s6_done_pulse", e_done, 0);
    adv(10); chk("s6_no_lockup", e_busy, 0);
    loop = 1'b0;
    adv(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
